// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory responder: burst and response codes,
// and the state encodings of the write and read channel FSMs.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // FIXED holds the beat address; INCR and WRAP both advance one word.
    function automatic logic burst_advances(input logic [1:0] burst);
        return burst != BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed storage for axi_mem_slave.
// Ports: clk; byte-enabled synchronous write port (we, waddr, wdata, wstrb);
// combinational read port (raddr -> rdata_c). A read of the word being written
// in the same cycle returns the pre-write contents. Contents are not reset.
module axi_mem_array
    import axi_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W/8-1:0]     wstrb,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    output logic [DATA_W-1:0]       rdata_c
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder serving write and read bursts from an internal array.
// Write and read channels run independent FSMs; one outstanding burst per
// direction. FIXED bursts hold the address, INCR/WRAP advance 4 bytes a beat.
// Ports: ACLK, ARESETN (async active-low); AW*/W*/B* write channels;
// AR*/R* read channels; all outputs registered.
// Build option: AXI_MEM_RANGE_CHECK_EN -- beats addressing beyond the array
// are dropped (writes) or return zero (reads) with SLVERR. Without it the
// upper address bits are ignored and the word index wraps modulo the depth.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int MEM_WORDS_LOG2   = 10
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_AXI_ID_WIDTH-1:0]     AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic [2:0]                    AWSIZE,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]     ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [2:0]                    ARSIZE,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     RID,
    output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int unsigned DATA_W = C_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W = C_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W  = MEM_WORDS_LOG2;
    localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(4);

    // Write channel state
    wstate_t             wstate_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [7:0]          wlen_q;
    logic [7:0]          wcnt_q;
    logic                wincr_q;
    logic                werr_q;

    // Read channel state
    rstate_t             rstate_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [7:0]          rlen_q;
    logic [7:0]          rcnt_q;
    logic                rincr_q;

    logic                w_fire_c;
    logic                w_last_beat_c;
    logic                w_in_range_c;
    logic                w_beat_err_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic                r_in_range_c;
    logic [DATA_W-1:0]   mem_rdata_c;
    logic [DATA_W-1:0]   r_beat_data_c;
    logic [1:0]          r_beat_resp_c;
    logic                unused_bits;

    assign w_fire_c      = (wstate_q == W_DATA) && WVALID && WREADY;
    assign w_last_beat_c = (wcnt_q == wlen_q);

    // The next read beat comes straight from ARADDR on acceptance, otherwise
    // from the running burst address.
    assign rd_addr_c = (rstate_q == R_IDLE) ? ARADDR : raddr_q;

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign w_in_range_c = (awaddr_q  >> (IDX_W + 2)) == '0;
    assign r_in_range_c = (rd_addr_c >> (IDX_W + 2)) == '0;
`else
    assign w_in_range_c = 1'b1;
    assign r_in_range_c = 1'b1;
`endif

    // A wrong WLAST on any beat, or an out-of-range beat, poisons the response.
    assign w_beat_err_c  = (WLAST != w_last_beat_c) || !w_in_range_c;
    assign mem_we_c      = w_fire_c && w_in_range_c;
    assign r_beat_data_c = r_in_range_c ? mem_rdata_c : '0;
    assign r_beat_resp_c = r_in_range_c ? RESP_OKAY : RESP_SLVERR;

    // AxSIZE and the byte offset bits play no part in addressing.
    assign unused_bits = ^{AWSIZE, ARSIZE, awaddr_q, rd_addr_c};

    axi_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (IDX_W)
    ) u_array (
        .clk     (ACLK),
        .we      (mem_we_c),
        .waddr   (awaddr_q[IDX_W+1:2]),
        .wdata   (WDATA),
        .wstrb   (WSTRB),
        .raddr   (rd_addr_c[IDX_W+1:2]),
        .rdata_c (mem_rdata_c)
    );

    // Write FSM: address accept, data beats, response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q <= W_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= '0;
            BRESP    <= RESP_OKAY;
            awaddr_q <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wincr_q  <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        BID      <= AWID;
                        awaddr_q <= AWADDR;
                        wlen_q   <= AWLEN;
                        wcnt_q   <= 8'd0;
                        wincr_q  <= burst_advances(AWBURST);
                        werr_q   <= 1'b0;
                        wstate_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire_c) begin
                        if (w_last_beat_c) begin
                            WREADY   <= 1'b0;
                            BVALID   <= 1'b1;
                            BRESP    <= (werr_q || w_beat_err_c) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                            werr_q <= werr_q || w_beat_err_c;
                            if (wincr_q) begin
                                awaddr_q <= awaddr_q + BEAT_STEP;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        wstate_q <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: address accept loads beat 0, each R handshake loads the next.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate_q <= R_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rincr_q  <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        ARREADY  <= 1'b0;
                        RVALID   <= 1'b1;
                        RID      <= ARID;
                        RDATA    <= r_beat_data_c;
                        RRESP    <= r_beat_resp_c;
                        RLAST    <= (ARLEN == 8'd0);
                        rlen_q   <= ARLEN;
                        rcnt_q   <= 8'd0;
                        rincr_q  <= burst_advances(ARBURST);
                        raddr_q  <= burst_advances(ARBURST) ? ARADDR + BEAT_STEP : ARADDR;
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID   <= 1'b0;
                            RLAST    <= 1'b0;
                            ARREADY  <= 1'b1;
                            rstate_q <= R_IDLE;
                        end else begin
                            RDATA  <= r_beat_data_c;
                            RRESP  <= r_beat_resp_c;
                            RLAST  <= ((rcnt_q + 8'd1) == rlen_q);
                            rcnt_q <= rcnt_q + 8'd1;
                            if (rincr_q) begin
                                raddr_q <= raddr_q + BEAT_STEP;
                            end
                        end
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 memory responder: accepts write and read bursts from an AXI master and serves them from an internal word-addressed register array. Sits on the far end of the master's AXI port as the local memory target for simulation and small on-chip buffers. Write and read channels run independent state machines sharing one array.

## Interface
- C_AXI_DATA_WIDTH, 32, data bus width; WSTRB is C_AXI_DATA_WIDTH/8 bits
- C_AXI_ADDR_WIDTH, 32, byte address width
- C_AXI_ID_WIDTH, 1, ID width; IDs echoed on BID/RID
- MEM_WORDS_LOG2, 10, log2 of array depth in words
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address
- AWVALID in 1, AWREADY out 1  write address handshake
- WDATA/WSTRB/WLAST  in  DATA/DATA/8/1  write data, byte enables, last flag
- WVALID in 1, WREADY out 1  write data handshake
- BID/BRESP  out  ID/2  write response
- BVALID out 1, BREADY in 1  response handshake
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address
- ARVALID in 1, ARREADY out 1  read address handshake
- RID/RDATA/RRESP/RLAST  out  ID/DATA/2/1  read data
- RVALID out 1, RREADY in 1  read data handshake

## Operation
- Word index = addr[MEM_WORDS_LOG2+1:2]; addr[1:0] ignored; AxSIZE ignored (full-width beats).
- Burst: FIXED holds address; INCR and WRAP advance +4 per beat (WRAP treated as INCR). Beats = AxLEN+1; no 4 KB check.
- Write FSM: W_IDLE (AWREADY=1) -> AW handshake latches ID/addr/len/burst -> W_DATA (WREADY=1); each W handshake writes bytes where WSTRB=1; beat count == AWLEN -> W_RESP (BVALID=1) -> B handshake -> W_IDLE.
- WLAST does not end the burst; if WLAST mismatches the final-beat position on any beat, BRESP=SLVERR (data still written).
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake loads first beat -> R_DATA (RVALID=1); each R handshake loads next beat; RLAST=1 on beat ARLEN; handshake on last beat -> R_IDLE.
- Responses default OKAY (2'b00); SLVERR = 2'b10.
- Same-word collision: read beat loaded in the cycle a write lands returns pre-write data.
- Write and read never stall each other.

## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RDATA, RRESP = 0. AWREADY/ARREADY rise first cycle after ARESETN deasserts. Array contents not reset.
- AW handshake cycle N -> WREADY=1 at N+1; last W handshake at M -> BVALID at M+1, held with BID/BRESP stable until BREADY.
- AR handshake cycle N -> RVALID with beat 0 at N+1; full throughput: one beat per cycle while RREADY=1; RDATA/RLAST/RRESP stable while RVALID && !RREADY.
- AWREADY=0 outside W_IDLE; ARREADY=0 outside R_IDLE (one outstanding transaction per direction).
- ARESETN low mid-burst: immediate abort, all FSMs to IDLE, no response issued.

## Configuration
- AXI_MEM_RANGE_CHECK_EN defined: a burst whose start word index >= 2^MEM_WORDS_LOG2 or any beat beyond the array (address compared on all C_AXI_ADDR_WIDTH bits) -> out-of-range write beats dropped, BRESP=SLVERR; out-of-range read beats return RDATA=0, RRESP=SLVERR.
- Undefined: upper address bits ignored, index wraps modulo depth, responses always OKAY except WLAST mismatch.

## Structure
- Shared package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, write and read state enums.
- Sub-module axi_mem_array: 2^MEM_WORDS_LOG2 x C_AXI_DATA_WIDTH, one byte-enabled synchronous write port, one combinational read port.

## Test plan
- Single write AWADDR=0x10, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=0xF, then read 0x10 -> BRESP=OKAY one cycle after W; RDATA=0xDEADBEEF, RLAST=1.
- INCR write 4 beats at 0x100 (data 1..4), INCR read ARLEN=3 with RREADY held 1 -> RDATA 1,2,3,4 on consecutive cycles, RLAST on 4th only.
- WSTRB=0x3 write 0x0000AAAA over word 0x12345678 -> read returns 0x1234AAAA.
- RREADY low 3 cycles mid-burst, BREADY low 2 cycles -> RDATA/BVALID/BRESP held stable, no beat lost; WLAST asserted on beat 1 of 3 -> BRESP=SLVERR.
- With AXI_MEM_RANGE_CHECK_EN, MEM_WORDS_LOG2=10: write/read 0x1000 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0; without macro same access aliases word 0.
- ARESETN pulsed low during 8-beat read -> RVALID=0 immediately; new AR after release accepted and served correctly.
